// File: rtl/alu_driver.sv
// Sequencer between a request/response handshake and a tri-state ALU: drives
// operands, holds output enable for SETTLE cycles, captures the result.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a request; ALU output disabled
// S_DRIVE | operands on the ALU, alu_oe high, settle counter running
// S_RESP  | captured result presented until the consumer takes it
module alu_driver #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [3:0]  req_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic        rsp_zero,
  output logic [15:0] op_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [3:0] CAPTURE = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] settle_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cmd    <= '0;
      rsp_data   <= '0;
      rsp_cmd    <= '0;
      rsp_zero   <= 1'b1;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_cmd    <= req_cmd;
            settle_cnt <= '0;
            state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          // alu_d is only trusted here; it may float during the other cycles
          if (settle_cnt == CAPTURE) begin
            rsp_data <= alu_d;
            rsp_cmd  <= alu_cmd;
            rsp_zero <= (alu_d == 16'h0000);
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + 16'd1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign alu_oe    = (state == S_DRIVE);
  assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: SETTLE=1 instance for function/backpressure,
// SETTLE=4 instance for settle timing and mid-operation reset.
module tb_alu_driver;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a, b;
  logic [3:0]  cmd;

  logic        rv1, rr1, rdy1, oe1, vld1, z1;
  logic [7:0]  aa1, ab1;
  logic [3:0]  ac1, rc1;
  logic [15:0] d1, data1, cnt1;

  logic        rv4, rr4, rdy4, oe4, vld4, z4;
  logic [7:0]  aa4, ab4;
  logic [3:0]  ac4, rc4;
  logic [15:0] d4, data4, cnt4;

  int n_cmp = 0;
  int n_bad = 0;
  int dcnt  = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_BUF = 4'hF;

  alu_driver #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1),
    .req_a(a), .req_b(b), .req_cmd(cmd),
    .alu_a(aa1), .alu_b(ab1), .alu_cmd(ac1), .alu_oe(oe1), .alu_d(d1),
    .rsp_valid(vld1), .rsp_ready(rr1), .rsp_data(data1), .rsp_cmd(rc1),
    .rsp_zero(z1), .op_count(cnt1)
  );

  alu_driver #(.SETTLE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rdy4),
    .req_a(a), .req_b(b), .req_cmd(cmd),
    .alu_a(aa4), .alu_b(ab4), .alu_cmd(ac4), .alu_oe(oe4), .alu_d(d4),
    .rsp_valid(vld4), .rsp_ready(rr4), .rsp_data(data4), .rsp_cmd(rc4),
    .rsp_zero(z4), .op_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                        input logic [3:0] c);
    case (c)
      OP_ADD:  return {8'h00, x} + {8'h00, y};
      OP_SUB:  return {8'h00, x} - {8'h00, y};
      OP_MUL:  return {8'h00, x} * {8'h00, y};
      OP_XOR:  return {8'h00, x ^ y};
      default: return {8'h00, x};
    endcase
  endfunction

  // ALU model: floats whenever its output enable is low
  always_comb d1 = oe1 ? alu_f(aa1, ab1, ac1) : 16'hzzzz;

  // slow ALU: only valid in the 4th drive cycle
  always @(posedge clk) dcnt <= oe4 ? dcnt + 1 : 0;
  always_comb d4 = (oe4 && dcnt == 3) ? 16'hBEEF : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input logic [7:0] xa, input logic [7:0] xb, input logic [3:0] xc,
                     input logic [15:0] exp_d, input logic exp_z, input logic [15:0] exp_n);
    a = xa; b = xb; cmd = xc; rv1 = 1'b1;
    check("op_ready", 32'(rdy1), 32'd1);
    tick();
    rv1 = 1'b0;
    check("op_oe_drive", 32'(oe1), 32'd1);
    check("op_vld_drive", 32'(vld1), 32'd0);
    check("op_alu_a", 32'(aa1), 32'(xa));
    tick();
    check("op_oe_resp", 32'(oe1), 32'd0);
    check("op_vld_resp", 32'(vld1), 32'd1);
    check("op_data", 32'(data1), 32'(exp_d));
    check("op_zero", 32'(z1), 32'(exp_z));
    check("op_cmd", 32'(rc1), 32'(xc));
    tick();
    check("op_vld_idle", 32'(vld1), 32'd0);
    check("op_count", 32'(cnt1), 32'(exp_n));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; rv1 = 1'b0; rv4 = 1'b0; rr1 = 1'b1; rr4 = 1'b1;
    a = 8'h00; b = 8'h00; cmd = 4'h0;
    tick(); tick();
    rst_n = 1'b1;

    check("rst_ready", 32'(rdy1), 32'd1);
    check("rst_oe", 32'(oe1), 32'd0);
    check("rst_vld", 32'(vld1), 32'd0);
    check("rst_zero", 32'(z1), 32'd1);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_count", 32'(cnt1), 32'd0);

    op1(8'h0F, 8'h01, OP_ADD, 16'h0010, 1'b0, 16'd1);
    op1(8'hFF, 8'hFF, OP_MUL, 16'hFE01, 1'b0, 16'd2);
    op1(8'h00, 8'h01, OP_SUB, 16'hFFFF, 1'b0, 16'd3);
    op1(8'hAA, 8'hAA, OP_XOR, 16'h0000, 1'b1, 16'd4);

    // backpressure with a second request held pending
    rr1 = 1'b0;
    a = 8'h01; b = 8'h02; cmd = OP_ADD; rv1 = 1'b1;
    tick();
    a = 8'h05; b = 8'h06; cmd = OP_MUL;
    check("bp_alu_a_hold", 32'(aa1), 32'h01);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 32'(vld1), 32'd1);
      check("bp_data", 32'(data1), 32'h0003);
      check("bp_ready", 32'(rdy1), 32'd0);
      check("bp_oe", 32'(oe1), 32'd0);
      tick();
    end
    check("bp_vld_last", 32'(vld1), 32'd1);
    rr1 = 1'b1;
    tick();
    check("bp_ready_after", 32'(rdy1), 32'd1);
    check("bp_count", 32'(cnt1), 32'd5);
    check("bp_alu_a_idle", 32'(aa1), 32'h01);
    tick();
    rv1 = 1'b0;
    check("bp_accept_oe", 32'(oe1), 32'd1);
    check("bp_accept_a", 32'(aa1), 32'h05);
    check("bp_accept_cmd", 32'(ac1), 32'(OP_MUL));
    tick();
    check("bp_second_data", 32'(data1), 32'h001E);
    tick();
    check("bp_second_count", 32'(cnt1), 32'd6);

    // SETTLE=4 timing with a floating bus outside the 4th drive cycle
    a = 8'h12; b = 8'h34; cmd = OP_BUF; rv4 = 1'b1;
    tick();
    rv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s4_oe_drive", 32'(oe4), 32'd1);
      check("s4_vld_drive", 32'(vld4), 32'd0);
      tick();
    end
    check("s4_oe_resp", 32'(oe4), 32'd0);
    check("s4_vld_resp", 32'(vld4), 32'd1);
    check("s4_data", 32'(data4), 32'hBEEF);
    check("s4_zero", 32'(z4), 32'd0);
    check("s4_cmd", 32'(rc4), 32'(OP_BUF));
    tick();
    check("s4_count", 32'(cnt4), 32'd1);
    check("s4_oe_idle", 32'(oe4), 32'd0);

    // reset in the 2nd drive cycle aborts the operation
    a = 8'h77; rv4 = 1'b1;
    tick();
    rv4 = 1'b0;
    tick();
    check("abort_oe_before", 32'(oe4), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_oe", 32'(oe4), 32'd0);
    check("abort_ready", 32'(rdy4), 32'd1);
    check("abort_count", 32'(cnt4), 32'd0);
    check("abort_data", 32'(data4), 32'd0);
    check("abort_zero", 32'(z4), 32'd1);
    check("abort_alu_a", 32'(aa4), 32'd0);
    check("abort_s1_count", 32'(cnt1), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | vld4 | oe4;
      tick();
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_count_after", 32'(cnt4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
